// File: rtl/snn_lif_core.sv
// Leaky integrate-and-fire inference core: rate-codes pixels against an LFSR,
// accumulates signed weights into per-neuron membranes, leaks, fires and counts spikes.
module snn_lif_core #(
  parameter int NUM_INPUTS    = 196,
  parameter int NUM_OUTPUTS   = 10,
  parameter int NUM_TIMESTEPS = 100,
  parameter int VMEM_W        = 16,
  parameter int WEIGHT_W      = 8,
  parameter int PIX_W         = 8,
  parameter int LEAK_SHIFT    = 3,
  localparam int PA_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int WA_W = (NUM_INPUTS * NUM_OUTPUTS > 1) ? $clog2(NUM_INPUTS * NUM_OUTPUTS) : 1,
  localparam int TS_W = (NUM_TIMESTEPS > 1) ? $clog2(NUM_TIMESTEPS) : 1,
  localparam int NO_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [15:0]                seed,
  input  logic signed [VMEM_W-1:0]   v_th,
  output logic                       pix_req,
  output logic [PA_W-1:0]            pix_addr,
  input  logic                       pix_valid,
  input  logic [PIX_W-1:0]           pix_data,
  output logic                       w_req,
  output logic [WA_W-1:0]            w_addr,
  input  logic                       w_valid,
  input  logic signed [WEIGHT_W-1:0] w_data,
  output logic                       busy,
  output logic                       done,
  output logic [TS_W-1:0]            timestep,
  output logic [NUM_OUTPUTS-1:0]     out_spike,
  output logic [NO_W-1:0]            winner,
  input  logic [NO_W-1:0]            cnt_sel,
  output logic [15:0]                cnt_data
);

  typedef enum logic [2:0] {
    IDLE, FETCH_PIX, FETCH_W, LEAK, CHECK_END, DONE
  } state_t;

  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
  localparam logic signed [VMEM_W-1:0] VMAX = {1'b0, {(VMEM_W-1){1'b1}}};
  localparam logic signed [VMEM_W-1:0] VMIN = {1'b1, {(VMEM_W-1){1'b0}}};

  state_t                   r_state, w_next;
  logic [PA_W-1:0]          r_i;
  logic [NO_W-1:0]          r_j;
  logic [TS_W-1:0]          r_ts;
  logic [15:0]              r_lfsr;
  logic signed [VMEM_W-1:0] r_vmem [NUM_OUTPUTS];
  logic [15:0]              r_cnt  [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0]   r_spike;
  logic [NO_W-1:0]          r_winner;

  logic                     w_lastPix, w_lastNeuron, w_lastTs;
  logic [15:0]              w_lfsrNext;
  logic                     w_spike, w_pixAccept, w_wAccept, w_fire;
  logic signed [VMEM_W-1:0] w_vCur, w_sat, w_leaked;
  logic signed [VMEM_W:0]   w_sum;
  logic [NO_W-1:0]          w_bestIdx;
  logic [15:0]              w_bestCnt;

  assign w_lastPix    = (r_i == PA_W'(NUM_INPUTS - 1));
  assign w_lastNeuron = (r_j == NO_W'(NUM_OUTPUTS - 1));
  assign w_lastTs     = (r_ts == TS_W'(NUM_TIMESTEPS - 1));
  assign w_lfsrNext   = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_spike      = (w_lfsrNext[PIX_W-1:0] < pix_data);
  assign w_pixAccept  = (r_state == FETCH_PIX) && pix_valid && !abort;
  assign w_wAccept    = (r_state == FETCH_W) && w_valid && !abort;

  assign w_vCur   = r_vmem[r_j];
  assign w_sum    = {w_vCur[VMEM_W-1], w_vCur}
                  + {{(VMEM_W + 1 - WEIGHT_W){w_data[WEIGHT_W-1]}}, w_data};
  assign w_leaked = w_vCur - (w_vCur >>> LEAK_SHIFT);
  assign w_fire   = (w_leaked >= v_th);

  // Membrane accumulation clamps instead of wrapping so a strong neuron cannot flip sign.
  always_comb begin
    w_sat = w_sum[VMEM_W-1:0];
    if (w_sum[VMEM_W] != w_sum[VMEM_W-1])
      w_sat = w_sum[VMEM_W] ? VMIN : VMAX;
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    w_bestIdx = '0;
    w_bestCnt = r_cnt[0];
    for (int k = 1; k < NUM_OUTPUTS; k++) begin
      if (r_cnt[k] > w_bestCnt) begin
        w_bestCnt = r_cnt[k];
        w_bestIdx = NO_W'(k);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (start) w_next = FETCH_PIX;
      FETCH_PIX: if (pix_valid) begin
                   if (w_spike)        w_next = FETCH_W;
                   else if (w_lastPix) w_next = LEAK;
                 end
      FETCH_W:   if (w_valid && w_lastNeuron) w_next = w_lastPix ? LEAK : FETCH_PIX;
      LEAK:      if (w_lastNeuron) w_next = CHECK_END;
      CHECK_END: w_next = w_lastTs ? DONE : FETCH_PIX;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
    if (abort && r_state != IDLE) w_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i      <= '0;
      r_j      <= '0;
      r_ts     <= '0;
      r_lfsr   <= LFSR_DEFAULT;
      r_spike  <= '0;
      r_winner <= '0;
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
        r_vmem[k] <= '0;
        r_cnt[k]  <= '0;
      end
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_i     <= '0;
          r_j     <= '0;
          r_ts    <= '0;
          r_spike <= '0;
          r_lfsr  <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
          for (int k = 0; k < NUM_OUTPUTS; k++) begin
            r_vmem[k] <= '0;
            r_cnt[k]  <= '0;
          end
        end
        FETCH_PIX: if (w_pixAccept) begin
          r_lfsr <= w_lfsrNext;
          if (w_spike || w_lastPix) r_j <= '0;
          else                      r_i <= r_i + PA_W'(1);
        end
        FETCH_W: if (w_wAccept) begin
          r_vmem[r_j] <= w_sat;
          if (w_lastNeuron) begin
            r_j <= '0;
            if (!w_lastPix) r_i <= r_i + PA_W'(1);
          end else begin
            r_j <= r_j + NO_W'(1);
          end
        end
        LEAK: if (!abort) begin
          if (w_fire) begin
            r_vmem[r_j]  <= '0;
            r_spike[r_j] <= 1'b1;
            if (r_cnt[r_j] != 16'hFFFF) r_cnt[r_j] <= r_cnt[r_j] + 16'd1;
          end else begin
            r_vmem[r_j]  <= w_leaked;
            r_spike[r_j] <= 1'b0;
          end
          r_j <= w_lastNeuron ? '0 : r_j + NO_W'(1);
        end
        CHECK_END: if (!abort && !w_lastTs) begin
          r_ts <= r_ts + TS_W'(1);
          r_i  <= '0;
        end
        DONE: if (!abort) r_winner <= w_bestIdx;
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_data = '0;
    if (32'(cnt_sel) < NUM_OUTPUTS) cnt_data = r_cnt[cnt_sel];
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE) && !abort;
  assign pix_req   = (r_state == FETCH_PIX);
  assign w_req     = (r_state == FETCH_W);
  assign pix_addr  = r_i;
  assign w_addr    = WA_W'(r_i) * WA_W'(NUM_OUTPUTS) + WA_W'(r_j);
  assign timestep  = r_ts;
  assign out_spike = r_spike;
  assign winner    = r_winner;

endmodule

// File: tb/tb_snn_lif_core.sv
// Directed bench for snn_lif_core: small 4-input, 8-neuron, 3-timestep, 8-bit-membrane build
// served by bench-side pixel/weight memories, checked against hand values and a small LIF model.
module tb_snn_lif_core;

  localparam int NI = 4;
  localparam int NO = 8;
  localparam int NT = 3;
  localparam int VW = 8;

  logic clk = 1'b0;
  logic rst, start, abort, pix_valid, w_valid;
  logic [15:0] seed;
  logic signed [VW-1:0] v_th;
  logic [7:0] pix_data;
  logic signed [7:0] w_data;
  logic pix_req, w_req, busy, done;
  logic [1:0] pix_addr;
  logic [4:0] w_addr;
  logic [1:0] timestep;
  logic [NO-1:0] out_spike;
  logic [2:0] winner, cnt_sel;
  logic [15:0] cnt_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] pixMem [NI];
  int         wNeuron [NO];
  logic [7:0] wMem [NI*NO];
  int         expCnt [NO];
  logic [NO-1:0] expSpk;
  int expSpikePix, expWinner;
  int pixCnt, wCnt, cyc;
  logic gotDone;

  always #5 clk = ~clk;

  snn_lif_core #(
    .NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .NUM_TIMESTEPS(NT),
    .VMEM_W(VW), .WEIGHT_W(8), .PIX_W(8), .LEAK_SHIFT(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed), .v_th(v_th),
    .pix_req(pix_req), .pix_addr(pix_addr), .pix_valid(pix_valid), .pix_data(pix_data),
    .w_req(w_req), .w_addr(w_addr), .w_valid(w_valid), .w_data(w_data),
    .busy(busy), .done(done), .timestep(timestep), .out_spike(out_spike),
    .winner(winner), .cnt_sel(cnt_sel), .cnt_data(cnt_data)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsrStep(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  task automatic loadMem();
    for (int i = 0; i < NI; i++)
      for (int j = 0; j < NO; j++)
        wMem[i*NO + j] = 8'(wNeuron[j]);
  endtask

  // Reference LIF behaviour for every neuron, using the same weight on all pixels per neuron.
  task automatic modelRun(input logic [15:0] sd, input int th);
    logic [15:0] l;
    int vm [NO];
    int vp;
    l = (sd == 16'h0000) ? 16'hACE1 : sd;
    expSpikePix = 0;
    expSpk = '0;
    for (int n = 0; n < NO; n++) begin
      vm[n] = 0;
      expCnt[n] = 0;
    end
    for (int t = 0; t < NT; t++) begin
      for (int i = 0; i < NI; i++) begin
        l = lfsrStep(l);
        if (l[7:0] < pixMem[i]) begin
          expSpikePix++;
          for (int n = 0; n < NO; n++) begin
            vm[n] = vm[n] + wNeuron[n];
            if (vm[n] > 127)  vm[n] = 127;
            if (vm[n] < -128) vm[n] = -128;
          end
        end
      end
      for (int n = 0; n < NO; n++) begin
        vp = vm[n] - (vm[n] >>> 3);
        if (vp >= th) begin
          vm[n] = 0;
          expCnt[n]++;
          expSpk[n] = 1'b1;
        end else begin
          vm[n] = vp;
          expSpk[n] = 1'b0;
        end
      end
    end
    expWinner = 0;
    for (int n = 1; n < NO; n++)
      if (expCnt[n] > expCnt[expWinner]) expWinner = n;
  endtask

  // Starts an inference and serves pixel/weight requests until done or the cycle budget runs out.
  task automatic applyStimulus(input logic [15:0] sd, input int th, input int delay);
    int waitCnt;
    waitCnt = 0;
    seed = sd;
    v_th = 8'(th);
    pixCnt = 0;
    wCnt = 0;
    cyc = 0;
    gotDone = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (!gotDone && cyc < 3000) begin
      pix_valid = 1'b0;
      w_valid = 1'b0;
      if (done) begin
        gotDone = 1'b1;
      end else begin
        if (pix_req) begin
          if (waitCnt < delay) waitCnt++;
          else begin
            pix_valid = 1'b1;
            pix_data = pixMem[pix_addr];
            waitCnt = 0;
            pixCnt++;
          end
        end
        if (w_req) begin
          w_valid = 1'b1;
          w_data = wMem[w_addr];
          wCnt++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    pix_valid = 1'b0;
    w_valid = 1'b0;
  endtask

  task automatic runAndCheck(input string tag, input logic [15:0] sd, input int th, input int delay);
    loadMem();
    modelRun(sd, th);
    applyStimulus(sd, th, delay);
    checkOutput({tag, ".done"}, 32'(gotDone), 1);
    checkOutput({tag, ".pixFetches"}, pixCnt, NI*NT);
    checkOutput({tag, ".wFetches"}, wCnt, expSpikePix*NO);
    checkOutput({tag, ".timestep"}, 32'(timestep), NT-1);
    checkOutput({tag, ".outSpike"}, 32'(out_spike), 32'(expSpk));
    for (int k = 0; k < NO; k++) begin
      cnt_sel = 3'(k);
      #1;
      checkOutput({tag, ".cnt"}, 32'(cnt_data), expCnt[k]);
    end
    @(negedge clk);
    checkOutput({tag, ".donePulse"}, 32'(done), 0);
    checkOutput({tag, ".idle"}, 32'(busy), 0);
    checkOutput({tag, ".winner"}, 32'(winner), expWinner);
  endtask

  initial begin
    #4000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic seen;
    rst = 1'b1; start = 1'b0; abort = 1'b0; pix_valid = 1'b0; w_valid = 1'b0;
    seed = '0; v_th = '0; pix_data = '0; w_data = '0; cnt_sel = '0;
    for (int i = 0; i < NI; i++) pixMem[i] = 8'd0;
    for (int n = 0; n < NO; n++) wNeuron[n] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state, then stray valids while idle must be ignored.
    checkOutput("rst.busy", 32'(busy), 0);
    checkOutput("rst.done", 32'(done), 0);
    checkOutput("rst.pixReq", 32'(pix_req), 0);
    checkOutput("rst.wReq", 32'(w_req), 0);
    checkOutput("rst.timestep", 32'(timestep), 0);
    checkOutput("rst.winner", 32'(winner), 0);
    checkOutput("rst.outSpike", 32'(out_spike), 0);
    checkOutput("rst.cnt", 32'(cnt_data), 0);
    pix_valid = 1'b1; w_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0; w_valid = 1'b0;
    checkOutput("idleValid.busy", 32'(busy), 0);

    // All-zero pixels: no weight fetches, 3 x (4 pixel + 8 leak + 1 check) cycles.
    for (int n = 0; n < NO; n++) wNeuron[n] = 5;
    runAndCheck("zeroPix", 16'h1234, 40, 0);
    checkOutput("zeroPix.noW", wCnt, 0);
    checkOutput("zeroPix.cycles", cyc, 39);

    // Bright image, neuron0 strong, others weak; seed 0 selects the default LFSR seed.
    for (int i = 0; i < NI; i++) pixMem[i] = 8'd255;
    wNeuron[0] = 20;
    for (int n = 1; n < NO; n++) wNeuron[n] = 1;
    runAndCheck("main", 16'h0000, 40, 0);

    // Saturation: +127 per spike must clamp at 127 and still fire (a wrap would go negative).
    for (int n = 0; n < NO; n++) wNeuron[n] = 0;
    wNeuron[0] = 127;
    runAndCheck("sat", 16'hBEEF, 100, 0);
    cnt_sel = 3'd0;
    #1;
    checkOutput("sat.cnt0", 32'(cnt_data), 3);

    // Delayed pix_valid: request and address must hold until the data arrives.
    pixMem[0] = 8'd0;
    seed = 16'h0001; v_th = 8'sd40;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkOutput("hold.pixReq", 32'(pix_req), 1);
      checkOutput("hold.pixAddr", 32'(pix_addr), 0);
      @(negedge clk);
    end
    pix_valid = 1'b1; pix_data = 8'd0;
    @(negedge clk);
    pix_valid = 1'b0;
    checkOutput("hold.nextAddr", 32'(pix_addr), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("hold.abortIdle", 32'(busy), 0);
    checkOutput("hold.abortPixReq", 32'(pix_req), 0);
    pixMem[0] = 8'd255;
    wNeuron[0] = 20;
    for (int n = 1; n < NO; n++) wNeuron[n] = 1;
    runAndCheck("delayRun", 16'h0BAD, 40, 5);

    // Tie between neurons 3 and 7 resolves to the lower index.
    for (int n = 0; n < NO; n++) wNeuron[n] = 0;
    wNeuron[3] = 127;
    wNeuron[7] = 127;
    runAndCheck("tie", 16'h5A5A, 100, 0);
    checkOutput("tie.winner3", 32'(winner), 3);
    cnt_sel = 3'd7;
    #1;
    checkOutput("tie.cnt7", 32'(cnt_data), 3);

    // Abort in the same cycle as w_valid: back to idle, no done, winner kept.
    loadMem();
    seed = 16'h7777; v_th = 8'sd100;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      pix_valid = 1'b0;
      if (w_req) seen = 1'b1;
      else begin
        if (pix_req) begin
          pix_valid = 1'b1;
          pix_data = pixMem[pix_addr];
        end
        @(negedge clk);
      end
    end
    pix_valid = 1'b0;
    checkOutput("abortW.seen", 32'(seen), 1);
    w_valid = 1'b1; w_data = 8'sd127; abort = 1'b1;
    @(negedge clk);
    w_valid = 1'b0; abort = 1'b0;
    checkOutput("abortW.busy", 32'(busy), 0);
    checkOutput("abortW.wReq", 32'(w_req), 0);
    checkOutput("abortW.done", 32'(done), 0);
    checkOutput("abortW.winner", 32'(winner), 3);
    repeat (3) begin
      @(negedge clk);
      checkOutput("abortW.noDone", 32'(done), 0);
    end

    // Reset in the middle of an inference clears everything asynchronously.
    seed = 16'h3C3C;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (60) begin
      pix_valid = 1'b0; w_valid = 1'b0;
      if (pix_req) begin pix_valid = 1'b1; pix_data = pixMem[pix_addr]; end
      if (w_req)   begin w_valid = 1'b1;   w_data = wMem[w_addr];       end
      @(negedge clk);
    end
    pix_valid = 1'b0; w_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    cnt_sel = 3'd3;
    #1;
    checkOutput("rstMid.busy", 32'(busy), 0);
    checkOutput("rstMid.pixReq", 32'(pix_req), 0);
    checkOutput("rstMid.wReq", 32'(w_req), 0);
    checkOutput("rstMid.timestep", 32'(timestep), 0);
    checkOutput("rstMid.winner", 32'(winner), 0);
    checkOutput("rstMid.outSpike", 32'(out_spike), 0);
    checkOutput("rstMid.cnt3", 32'(cnt_data), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("rstMid.noDone", 32'(done), 0);
    end
    wNeuron[0] = 20;
    for (int n = 1; n < NO; n++) wNeuron[n] = 1;
    runAndCheck("postReset", 16'h2468, 40, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snn_lif_core.md
SNN_LIF_CORE -- requirements
Module: snn_lif_core

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 196, meaning input pixels per image.
REQ-002 SHALL have parameter NUM_OUTPUTS, default 10, meaning output LIF neurons.
REQ-003 SHALL have parameter NUM_TIMESTEPS, default 100, meaning timesteps per inference.
REQ-004 SHALL have parameter VMEM_W, default 16, meaning signed membrane width; WEIGHT_W, default 8, meaning signed weight width; PIX_W, default 8, meaning pixel width.
REQ-005 SHALL have parameter LEAK_SHIFT, default 3, meaning leak = vmem >>> LEAK_SHIFT.
REQ-006 SHALL have ports: clk in 1, clock; rst in 1, reset. One clock; reset is asynchronous and active-high.
REQ-007 SHALL have ports: start in 1, begin inference; abort in 1, cancel; seed in 16, LFSR seed; v_th in VMEM_W, signed firing threshold.
REQ-008 SHALL have ports: pix_req out 1; pix_addr out clog2(NUM_INPUTS); pix_valid in 1; pix_data in PIX_W.
REQ-009 SHALL have ports: w_req out 1; w_addr out clog2(NUM_INPUTS*NUM_OUTPUTS); w_valid in 1; w_data in WEIGHT_W signed.
REQ-010 SHALL have ports: busy out 1; done out 1, one-cycle pulse; timestep out clog2(NUM_TIMESTEPS); out_spike out NUM_OUTPUTS, per-timestep fire flags; winner out clog2(NUM_OUTPUTS); cnt_sel in clog2(NUM_OUTPUTS); cnt_data out 16, spike count of cnt_sel.

Function
REQ-011 SHALL implement states IDLE, FETCH_PIX, FETCH_W, LEAK, CHECK_END, DONE.
REQ-012 IDLE: busy=0; start=1 -> clear all vmem, spike counts, out_spike, timestep; pixel index i=0; LFSR <= seed (0xACE1 if seed==0); go FETCH_PIX. start ignored in any other state.
REQ-013 FETCH_PIX: pix_req=1, pix_addr=i held stable until pix_valid; on pix_valid advance 16-bit Fibonacci LFSR (taps 16,14,13,11) once; spike = (LFSR_next[PIX_W-1:0] < pix_data).
REQ-014 On spike=1 SHALL go FETCH_W with neuron index j=0; on spike=0 SHALL advance i, or go LEAK with j=0 when i==NUM_INPUTS-1.
REQ-015 FETCH_W: w_req=1, w_addr=i*NUM_OUTPUTS+j held stable until w_valid; on w_valid vmem[j] <= vmem[j] + sign-extended w_data, saturated to signed VMEM_W range (no wrap).
REQ-016 After accumulating j==NUM_OUTPUTS-1 SHALL advance i to FETCH_PIX, or go LEAK (j=0) when i==NUM_INPUTS-1.
REQ-017 LEAK: one neuron per cycle; v' = vmem[j] - (vmem[j] >>> LEAK_SHIFT) (arithmetic); if v' >= v_th (signed): vmem[j] <= 0, out_spike[j] <= 1, count[j] += 1 saturating at 0xFFFF; else vmem[j] <= v', out_spike[j] <= 0.
REQ-018 After j==NUM_OUTPUTS-1 in LEAK SHALL go CHECK_END.
REQ-019 CHECK_END: if timestep==NUM_TIMESTEPS-1 go DONE; else timestep+1, i=0, go FETCH_PIX; vmem and counts persist across timesteps.
REQ-020 DONE: register winner = index of max count, lowest index on tie; done=1 for exactly this cycle; next state IDLE.
REQ-021 abort=1 in any non-IDLE state SHALL go IDLE next cycle, drop pix_req/w_req, no done pulse, winner unchanged; abort has priority over pix_valid/w_valid in the same cycle.
REQ-022 busy SHALL be 1 in all states except IDLE; pix_req and w_req SHALL never both be 1.
REQ-023 pix_valid/w_valid while the matching req=0 SHALL be ignored.
REQ-024 cnt_data SHALL be combinational count[cnt_sel]; cnt_sel >= NUM_OUTPUTS returns 0.

Reset
REQ-025 rst=1 SHALL asynchronously force IDLE, busy=0, done=0, pix_req=0, w_req=0, timestep=0, winner=0, out_spike=0, all vmem=0, all counts=0, LFSR=0xACE1.
REQ-026 rst asserted mid-inference SHALL behave as REQ-025; no done pulse on release; first start after release runs a full inference.

Verification
REQ-027 NUM_INPUTS=4, NUM_OUTPUTS=2, NUM_TIMESTEPS=1, all pixels 0 -> no w_req ever, vmem stays 0, done after 4 pixel fetches + 2 LEAK cycles, winner=0.
REQ-028 All pixels 255, weights neuron0=+20 neuron1=+1, v_th=40, LEAK_SHIFT=3, NUM_TIMESTEPS=3 -> count0=3, count1=0, winner=0, out_spike=01 at each timestep end (pixels drawing LFSR==255 give no spike; bench models LFSR).
REQ-029 VMEM_W=8, weight +127 repeated, v_th=127 -> vmem saturates at 127, never wraps negative.
REQ-030 pix_valid delayed 5 cycles -> pix_req/pix_addr held stable 5 cycles, one LFSR step only.
REQ-031 abort asserted same cycle as w_valid -> IDLE next cycle, vmem not updated, no done; start then runs normally.
REQ-032 Equal counts on neurons 3 and 7 (both max) -> winner=3.
